// File: rtl/adc_responder_if.sv
// Serial bus between an ADC-style master and the responder.
// The master owns chip select, serial clock and command data; the responder drives the result.
interface adc_responder_if;
    logic adc_cs;
    logic adc_clk;
    logic adc_din;
    logic adc_dout;
    logic adc_dout_oe;

    modport master (
        output adc_cs,
        output adc_clk,
        output adc_din,
        input  adc_dout,
        input  adc_dout_oe
    );

    modport slave (
        input  adc_cs,
        input  adc_clk,
        input  adc_din,
        output adc_dout,
        output adc_dout_oe
    );
endinterface

// File: rtl/adc_responder.sv
// Emulates a two-channel 10-bit serial ADC: takes a start bit plus a three-bit configuration,
// then shifts back a null bit and the conversion result, MSB-first with an optional LSB-first echo.
module adc_responder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    adc_responder_if.slave        bus,
    input  logic [9:0]            sample_ch0,
    input  logic [9:0]            sample_ch1,
    output logic                  cfg_sgl,
    output logic                  cfg_odd,
    output logic                  cfg_msbf,
    output logic                  frame_done,
    output logic                  frame_err
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_START,
        CONFIG,
        NULL_BIT,
        DATA_MSB,
        DATA_LSB,
        TAIL
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] cs_sync, clk_sync, din_sync, fill;
    logic cs_s, clk_s, din_s, cs_prev, clk_prev;
    logic sync_ready, armed;
    logic rise, fall, cs_rise;

    logic [3:0] cnt, cnt_next;
    logic [9:0] result, result_next, pick;
    logic [9:0] in_plus, in_minus;
    logic [10:0] diff;
    logic dout, dout_next, oe, oe_next;
    logic sgl_next, odd_next, msbf_next;
    logic done_next, err_next;

    assign cs_s       = cs_sync[SYNC_STAGES-1];
    assign clk_s      = clk_sync[SYNC_STAGES-1];
    assign din_s      = din_sync[SYNC_STAGES-1];
    assign sync_ready = fill[SYNC_STAGES-1];

    assign rise    = clk_s & ~clk_prev & ~cs_s;
    assign fall    = ~clk_s & clk_prev & ~cs_s;
    assign cs_rise = cs_s & ~cs_prev;

    assign bus.adc_dout    = dout;
    assign bus.adc_dout_oe = oe;

    // The fill shadow marks when the synchroniser holds real pin values rather than reset values,
    // so a chip select held low across reset release is not mistaken for a fresh frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_sync  <= '1;
            clk_sync <= '0;
            din_sync <= '0;
            fill     <= '0;
            cs_prev  <= 1'b1;
            clk_prev <= 1'b0;
            armed    <= 1'b0;
        end else begin
            cs_sync  <= {cs_sync[SYNC_STAGES-2:0], bus.adc_cs};
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], bus.adc_clk};
            din_sync <= {din_sync[SYNC_STAGES-2:0], bus.adc_din};
            fill     <= {fill[SYNC_STAGES-2:0], 1'b1};
            cs_prev  <= cs_s;
            clk_prev <= clk_s;
            armed    <= armed | (sync_ready & cs_s);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            result     <= '0;
            dout       <= 1'b0;
            oe         <= 1'b0;
            cfg_sgl    <= 1'b0;
            cfg_odd    <= 1'b0;
            cfg_msbf   <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            result     <= result_next;
            dout       <= dout_next;
            oe         <= oe_next;
            cfg_sgl    <= sgl_next;
            cfg_odd    <= odd_next;
            cfg_msbf   <= msbf_next;
            frame_done <= done_next;
            frame_err  <= err_next;
        end
    end

    // Differential results below zero clamp to 0 instead of wrapping.
    always_comb begin
        in_plus  = cfg_odd ? sample_ch1 : sample_ch0;
        in_minus = cfg_odd ? sample_ch0 : sample_ch1;
        diff     = {1'b0, in_plus} - {1'b0, in_minus};
        if (cfg_sgl) begin
            pick = in_plus;
        end else if (diff[10]) begin
            pick = '0;
        end else begin
            pick = diff[9:0];
        end
    end

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        result_next = result;
        dout_next   = dout;
        oe_next     = oe;
        sgl_next    = cfg_sgl;
        odd_next    = cfg_odd;
        msbf_next   = cfg_msbf;
        done_next   = 1'b0;
        err_next    = 1'b0;

        // Chip select release wins over any serial clock edge seen in the same cycle.
        if (cs_rise) begin
            state_next = IDLE;
            dout_next  = 1'b0;
            oe_next    = 1'b0;
            done_next  = (state == TAIL);
            err_next   = (state == CONFIG) || (state == NULL_BIT) ||
                         (state == DATA_MSB) || (state == DATA_LSB);
        end else begin
            case (state)
                IDLE: begin
                    if (armed && !cs_s) state_next = WAIT_START;
                end
                WAIT_START: begin
                    if (rise && din_s) begin
                        state_next = CONFIG;
                        cnt_next   = '0;
                    end
                end
                CONFIG: begin
                    if (rise) begin
                        cnt_next = cnt + 4'd1;
                        case (cnt)
                            4'd0:    sgl_next = din_s;
                            4'd1:    odd_next = din_s;
                            default: begin
                                msbf_next   = din_s;
                                result_next = pick;
                                state_next  = NULL_BIT;
                            end
                        endcase
                    end
                end
                NULL_BIT: begin
                    if (fall) begin
                        dout_next  = 1'b0;
                        oe_next    = 1'b1;
                        cnt_next   = 4'd9;
                        state_next = DATA_MSB;
                    end
                end
                DATA_MSB: begin
                    if (fall) begin
                        dout_next = result[cnt];
                        if (cnt == 4'd0) begin
                            cnt_next   = 4'd1;
                            state_next = cfg_msbf ? TAIL : DATA_LSB;
                        end else begin
                            cnt_next = cnt - 4'd1;
                        end
                    end
                end
                DATA_LSB: begin
                    if (fall) begin
                        dout_next = result[cnt];
                        if (cnt == 4'd9) begin
                            state_next = TAIL;
                        end else begin
                            cnt_next = cnt + 4'd1;
                        end
                    end
                end
                TAIL: begin
                    if (fall) dout_next = 1'b0;
                end
                default: state_next = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_responder.sv
// Directed bench for adc_responder: plays the serial master and checks returned bits,
// configuration capture and frame completion pulses against hand-computed values.
module tb_adc_responder;

    localparam int HALF = 8;

    logic       clk;
    logic       rst;
    logic [9:0] sample_ch0;
    logic [9:0] sample_ch1;
    logic       cfg_sgl, cfg_odd, cfg_msbf;
    logic       frame_done, frame_err;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int err_cnt = 0;

    adc_responder_if bus ();

    adc_responder #(.SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .sample_ch0 (sample_ch0),
        .sample_ch1 (sample_ch1),
        .cfg_sgl    (cfg_sgl),
        .cfg_odd    (cfg_odd),
        .cfg_msbf   (cfg_msbf),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done === 1'b1) done_cnt++;
        if (frame_err === 1'b1) err_cnt++;
    end

    // One serial clock period; dout is sampled just before the rising edge, as the master would.
    task automatic spi_clock(input logic d, output logic so, output logic soe);
        bus.adc_din = d;
        repeat (HALF) @(negedge clk);
        so  = bus.adc_dout;
        soe = bus.adc_dout_oe;
        bus.adc_clk = 1'b1;
        repeat (HALF) @(negedge clk);
        bus.adc_clk = 1'b0;
    endtask

    task automatic shift_frame(input int lead, input logic [3:0] cmd, input int nread,
                               input logic [9:0] ch0_late, output logic [31:0] rx,
                               output logic oe_all, output logic oe_any);
        logic d, o;
        bus.adc_cs = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < lead; i++) spi_clock(1'b0, d, o);
        for (int i = 3; i >= 0; i--) spi_clock(cmd[i], d, o);
        sample_ch0 = ch0_late;
        rx = '0;
        oe_all = 1'b1;
        oe_any = 1'b0;
        for (int i = 0; i < nread; i++) begin
            spi_clock(1'b0, d, o);
            rx = {rx[30:0], d};
            oe_all = oe_all & o;
            oe_any = oe_any | o;
        end
    endtask

    task automatic end_frame();
        bus.adc_cs = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (bus.adc_dout_oe !== 1'b0) begin errors++; $display("[TB] FAIL reset_oe: got %b expected 0", bus.adc_dout_oe); end
        checks++; if (bus.adc_dout !== 1'b0) begin errors++; $display("[TB] FAIL reset_dout: got %b expected 0", bus.adc_dout); end
        checks++; if ({cfg_sgl, cfg_odd, cfg_msbf} !== 3'b000) begin errors++; $display("[TB] FAIL reset_cfg: got %b expected 000", {cfg_sgl, cfg_odd, cfg_msbf}); end
        checks++; if ({frame_done, frame_err} !== 2'b00) begin errors++; $display("[TB] FAIL reset_pulses: got %b expected 00", {frame_done, frame_err}); end
        rst = 1'b0;
        repeat (2 * HALF) @(negedge clk);
        checks++; if (bus.adc_dout_oe !== 1'b0) begin errors++; $display("[TB] FAIL idle_oe: got %b expected 0", bus.adc_dout_oe); end
    endtask

    task automatic test_single_ended(input int lead, input string tag);
        logic [31:0] rx;
        logic oe_all, oe_any;
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        sample_ch0 = 10'h2A5;
        sample_ch1 = 10'h155;
        shift_frame(lead, 4'b1101, 14, 10'h000, rx, oe_all, oe_any);
        checks++; if (rx[13:0] !== 14'b0_1010100101_000) begin errors++; $display("[TB] FAIL %s_data: got %b expected %b", tag, rx[13:0], 14'b0_1010100101_000); end
        checks++; if (oe_all !== 1'b1) begin errors++; $display("[TB] FAIL %s_oe: got %b expected 1", tag, oe_all); end
        checks++; if ({cfg_sgl, cfg_odd, cfg_msbf} !== 3'b101) begin errors++; $display("[TB] FAIL %s_cfg: got %b expected 101", tag, {cfg_sgl, cfg_odd, cfg_msbf}); end
        end_frame();
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("[TB] FAIL %s_done: got %0d expected 1", tag, done_cnt - d0); end
        checks++; if (err_cnt - e0 !== 0) begin errors++; $display("[TB] FAIL %s_err: got %0d expected 0", tag, err_cnt - e0); end
        checks++; if (bus.adc_dout_oe !== 1'b0) begin errors++; $display("[TB] FAIL %s_release: got %b expected 0", tag, bus.adc_dout_oe); end
    endtask

    task automatic test_diff_saturation();
        logic [31:0] rx;
        logic oe_all, oe_any;
        sample_ch0 = 10'd100;
        sample_ch1 = 10'd300;
        shift_frame(0, 4'b1001, 14, 10'd100, rx, oe_all, oe_any);
        checks++; if (rx[13:0] !== 14'b0) begin errors++; $display("[TB] FAIL diff_sat_data: got %b expected %b", rx[13:0], 14'b0); end
        checks++; if (oe_all !== 1'b1) begin errors++; $display("[TB] FAIL diff_sat_oe: got %b expected 1", oe_all); end
        checks++; if ({cfg_sgl, cfg_odd, cfg_msbf} !== 3'b001) begin errors++; $display("[TB] FAIL diff_sat_cfg: got %b expected 001", {cfg_sgl, cfg_odd, cfg_msbf}); end
        end_frame();
        shift_frame(0, 4'b1011, 14, 10'd100, rx, oe_all, oe_any);
        checks++; if (rx[13:0] !== 14'b0_0011001000_000) begin errors++; $display("[TB] FAIL diff_odd_data: got %b expected %b", rx[13:0], 14'b0_0011001000_000); end
        end_frame();
        checks++; if ({cfg_sgl, cfg_odd, cfg_msbf} !== 3'b011) begin errors++; $display("[TB] FAIL diff_cfg_hold: got %b expected 011", {cfg_sgl, cfg_odd, cfg_msbf}); end
    endtask

    task automatic test_lsb_first();
        logic [31:0] rx;
        logic oe_all, oe_any;
        int d0;
        d0 = done_cnt;
        sample_ch0 = 10'h011;
        sample_ch1 = 10'h3C1;
        shift_frame(0, 4'b1110, 23, 10'h011, rx, oe_all, oe_any);
        checks++; if (rx[22:0] !== 23'b0_1111000001_000001111_000) begin errors++; $display("[TB] FAIL lsb_data: got %b expected %b", rx[22:0], 23'b0_1111000001_000001111_000); end
        checks++; if (oe_all !== 1'b1) begin errors++; $display("[TB] FAIL lsb_oe: got %b expected 1", oe_all); end
        checks++; if ({cfg_sgl, cfg_odd, cfg_msbf} !== 3'b110) begin errors++; $display("[TB] FAIL lsb_cfg: got %b expected 110", {cfg_sgl, cfg_odd, cfg_msbf}); end
        end_frame();
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("[TB] FAIL lsb_done: got %0d expected 1", done_cnt - d0); end
    endtask

    task automatic test_abort();
        logic [31:0] rx;
        logic oe_all, oe_any;
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        sample_ch0 = 10'h2A5;
        shift_frame(0, 4'b1101, 5, 10'h2A5, rx, oe_all, oe_any);
        checks++; if (rx[4:0] !== 5'b01010) begin errors++; $display("[TB] FAIL abort_data: got %b expected 01010", rx[4:0]); end
        end_frame();
        checks++; if (err_cnt - e0 !== 1) begin errors++; $display("[TB] FAIL abort_err: got %0d expected 1", err_cnt - e0); end
        checks++; if (done_cnt - d0 !== 0) begin errors++; $display("[TB] FAIL abort_done: got %0d expected 0", done_cnt - d0); end
        checks++; if (bus.adc_dout_oe !== 1'b0) begin errors++; $display("[TB] FAIL abort_oe: got %b expected 0", bus.adc_dout_oe); end
        test_single_ended(0, "after_abort");
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] rx;
        logic oe_all, oe_any;
        int d0, e0;
        sample_ch0 = 10'h2A5;
        shift_frame(0, 4'b1101, 3, 10'h2A5, rx, oe_all, oe_any);
        d0 = done_cnt; e0 = err_cnt;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (2 * HALF) @(negedge clk);
        checks++; if (bus.adc_dout_oe !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_oe: got %b expected 0", bus.adc_dout_oe); end
        shift_frame(0, 4'b1101, 14, 10'h2A5, rx, oe_all, oe_any);
        checks++; if (oe_any !== 1'b0) begin errors++; $display("[TB] FAIL rst_cs_held_oe: got %b expected 0", oe_any); end
        checks++; if (rx[13:0] !== 14'b0) begin errors++; $display("[TB] FAIL rst_cs_held_data: got %b expected %b", rx[13:0], 14'b0); end
        end_frame();
        checks++; if (done_cnt - d0 !== 0 || err_cnt - e0 !== 0) begin errors++; $display("[TB] FAIL rst_pulses: got done=%0d err=%0d expected 0/0", done_cnt - d0, err_cnt - e0); end
        test_single_ended(0, "after_rst");
    endtask

    initial begin
        rst = 1'b1;
        bus.adc_cs = 1'b1;
        bus.adc_clk = 1'b0;
        bus.adc_din = 1'b0;
        sample_ch0 = '0;
        sample_ch1 = '0;
        test_reset();
        test_single_ended(0, "se");
        test_diff_saturation();
        test_lsb_first();
        test_single_ended(3, "lead0");
        test_abort();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
